// File: rtl/inv_ring_meter_pkg.sv
// Package: inv_meter_pkg
// Shared types and constants for the inverter ring frequency meter.
//   meter_state_e  : measurement sequencer states (2-bit)
//   settle_cycles  : cycles spent in SETTLE for a given synchroniser depth
//   *_DEF          : default widths used by the top level
package inv_meter_pkg;

  localparam int WIN_W_DEF       = 16;
  localparam int CNT_W_DEF       = 20;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } meter_state_e;

  // One extra cycle beyond the synchroniser depth so the edge-detect
  // register also holds a flushed sample before counting begins.
  function automatic int settle_cycles(input int sync_stages);
    return sync_stages + 1;
  endfunction

  localparam int SETTLE_CYCLES = settle_cycles(SYNC_STAGES_DEF);

endpackage

// File: rtl/inv_ring_meter_sync.sv
// Module: bit_sync
// Plain flop chain bringing an asynchronous level into the ck domain.
// Reset only makes simulation deterministic; function does not rely on it.
// Ports:
//   ck  in  clock
//   rst in  synchronous reset, active-high
//   d   in  asynchronous input
//   q   out synchronised output (STAGES cycles latency)
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic ck,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge ck) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/inv_ring_meter.sv
// Module: inv_ring_meter
// Enables an inverter ring oscillator, synchronises its tap and counts rising
// edges over a programmable window of ck cycles.
// Ports:
//   ck       in   clock
//   rst      in   synchronous reset, active-high
//   start    in   measurement request, accepted only in IDLE
//   win_len  in   window length in ck cycles, sampled on acceptance
//   ring_in  in   asynchronous ring tap
//   ring_en  out  ring enable (1 = oscillate)
//   busy     out  high from acceptance through the done cycle
//   done     out  one-cycle pulse, count/ovf valid
//   count    out  saturating rising-edge count of last window
//   ovf      out  count saturated during last measurement
//
// state   | meaning
// IDLE    | waiting for start; count/ovf hold last result
// SETTLE  | ring running, synchroniser flushing, edges ignored
// MEASURE | counting synchronised rising edges for win_len cycles
// DONE    | done pulse, ring stopped
module inv_ring_meter
  import inv_meter_pkg::*;
#(
  parameter int WIN_W       = WIN_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ring_in,
  output logic             ring_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  // Shared settle/window timer; at least 2 bits so the settle preload fits.
  localparam int TMR_W = (WIN_W > 2) ? WIN_W : 2;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(settle_cycles(SYNC_STAGES) - 1);

  meter_state_e     state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ring_en_q, ring_en_d;
  logic             s_q, s_d;
  logic             s_sync;
  logic             rise;
  logic             tmr_zero;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .ck  (ck),
    .rst (rst),
    .d   (ring_in),
    .q   (s_sync)
  );

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    // s_q tracks the synchronised level every cycle, so on MEASURE entry it
    // already holds the previous level and a steady high is not an edge.
    s_d      = s_sync;
    rise     = s_sync & ~s_q;
    tmr_zero = (tmr_q == '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          win_d   = win_len;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          tmr_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          if (win_q == '0) begin
            state_d = DONE;
          end else begin
            tmr_d   = TMR_W'(win_q) - TMR_W'(1);
            state_d = MEASURE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      MEASURE: begin
        if (rise) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          else             ovf_d = 1'b1;
        end
        if (tmr_zero) state_d = DONE;
        else          tmr_d   = tmr_q - TMR_W'(1);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered so the analog enable never sees decode glitches.
    ring_en_d = (state_d == SETTLE) || (state_d == MEASURE);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ring_en_q <= 1'b0;
      s_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      ring_en_q <= ring_en_d;
      s_q       <= s_d;
    end
  end

  assign ring_en = ring_en_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign count   = cnt_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_inv_ring_meter.sv
module tb_inv_ring_meter;

  localparam int WIN_W  = 16;
  localparam int CNT_W  = 20;
  localparam int CNT4_W = 4;

  logic             ck = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             ring_in = 1'b0;
  logic [WIN_W-1:0] win_len = '0;

  logic              ring_en, busy, done, ovf;
  logic [CNT_W-1:0]  count;
  logic              ring_en4, busy4, done4, ovf4;
  logic [CNT4_W-1:0] count4;

  always #5 ck = ~ck;

  inv_ring_meter #(.WIN_W(WIN_W), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .ck(ck), .rst(rst), .start(start), .win_len(win_len), .ring_in(ring_in),
    .ring_en(ring_en), .busy(busy), .done(done), .count(count), .ovf(ovf)
  );

  inv_ring_meter #(.WIN_W(WIN_W), .CNT_W(CNT4_W), .SYNC_STAGES(2)) dut4 (
    .ck(ck), .rst(rst), .start(start), .win_len(win_len), .ring_in(ring_in),
    .ring_en(ring_en4), .busy(busy4), .done(done4), .count(count4), .ovf(ovf4)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit hist[$];          // ring_in value sampled at each rising edge
  int ring_mode = 0;    // 0 low, 1 high, 2 square, 3 random
  int half_per  = 1;

  int exp_cnt  = 0;
  int exp_ovf  = 0;
  int exp_cnt4 = 0;
  int exp_ovf4 = 0;

  function automatic bit gen_ring();
    case (ring_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return bit'((cyc / half_per) % 2);
      default: return bit'($urandom_range(0, 1));
    endcase
  endfunction

  // Rising edges visible through a 2-flop synchroniser plus edge detect in
  // a window whose start was sampled at edge n: tap samples n+1 .. n+1+w.
  function automatic int model_rises(input int n, input int w);
    int r = 0;
    for (int j = n + 2; j <= n + 1 + w; j++)
      if (hist[j] && !hist[j-1]) r++;
    return r;
  endfunction

  function automatic int sat(input int r, input int maxv);
    return (r > maxv) ? maxv : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    hist.push_back(ring_in);
    cyc++;
    @(negedge ck);
    ring_in = gen_ring();
  endtask

  task automatic measure(input int w, input bit poke, input bit hold);
    int n;
    int r;
    win_len = WIN_W'(w);
    start   = 1'b1;
    n       = cyc;
    tick();
    for (int e = 1; e <= w + 5; e++) begin
      chk("ring_en",  ring_en,  (e <= w + 3));
      chk("busy",     busy,     (e <= w + 4));
      chk("done",     done,     (e == w + 4));
      chk("ring_en4", ring_en4, (e <= w + 3));
      chk("busy4",    busy4,    (e <= w + 4));
      if (e == w + 4) begin
        r        = model_rises(n, w);
        exp_cnt  = sat(r, (1 << CNT_W) - 1);
        exp_ovf  = (r > (1 << CNT_W) - 1) ? 1 : 0;
        exp_cnt4 = sat(r, (1 << CNT4_W) - 1);
        exp_ovf4 = (r > (1 << CNT4_W) - 1) ? 1 : 0;
        chk("count",  count,  exp_cnt);
        chk("ovf",    ovf,    exp_ovf);
        chk("count4", count4, exp_cnt4);
        chk("ovf4",   ovf4,   exp_ovf4);
        chk("done4",  done4,  1);
      end
      if (e == w + 5) begin
        chk("count_hold",  count,  exp_cnt);
        chk("count4_hold", count4, exp_cnt4);
      end
      if (hold)
        start = 1'b1;
      else if (poke && e < w + 4) begin
        start   = 1'($urandom_range(0, 1));
        win_len = WIN_W'($urandom);
      end else if (poke && e == w + 4)
        start = 1'b1;
      else
        start = 1'b0;
      if (e < w + 5) tick();
    end
  endtask

  initial begin
    int prev_hold;
    int w;
    int pk;
    int hd;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ring_en", ring_en, 0);
    chk("rst_busy",    busy,    0);
    chk("rst_done",    done,    0);
    chk("rst_count",   count,   0);
    chk("rst_ovf",     ovf,     0);
    rst = 1'b0;
    repeat (3) tick();

    // ck/8 ring, 64-cycle window
    ring_mode = 2; half_per = 4;
    measure(64, 0, 0);
    repeat (2) tick();

    // Zero-length window
    ring_mode = 3;
    measure(0, 0, 0);
    chk("zero_win_count", count, 0);
    tick();

    // Saturation in narrow counter, then cleared by next start
    ring_mode = 2; half_per = 1;
    measure(40, 0, 0);
    chk("sat_count4", count4, 15);
    chk("sat_ovf4",   ovf4,   1);
    ring_mode = 0;
    repeat (3) tick();
    measure(10, 0, 0);
    chk("clr_ovf4",   ovf4,   0);
    chk("clr_count4", count4, 0);

    // Reset mid-measure aborts with no done pulse
    ring_mode = 2; half_per = 3;
    win_len = WIN_W'(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("pre_abort_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("abort_ring_en", ring_en, 0);
    chk("abort_busy",    busy,    0);
    chk("abort_count",   count,   0);
    chk("abort_done",    done,    0);
    tick();
    rst = 1'b0;
    exp_cnt = 0; exp_cnt4 = 0; exp_ovf = 0; exp_ovf4 = 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end

    // Tap already high before start: no false edge
    ring_mode = 1;
    repeat (4) tick();
    measure(20, 0, 0);
    chk("high_level_count", count, 0);
    tick();

    // Start pokes while busy, then held start back-to-back
    ring_mode = 3;
    measure(12, 1, 0);
    measure(5, 0, 1);
    measure(7, 0, 1);
    measure(1, 0, 0);
    repeat (2) tick();

    // Randomised windows and tap patterns
    prev_hold = 0;
    for (int i = 0; i < 14; i++) begin
      ring_mode = ($urandom_range(0, 1) == 0) ? 2 : 3;
      half_per  = $urandom_range(1, 6);
      w  = (i == 0) ? 1 : $urandom_range(0, 60);
      pk = $urandom_range(0, 1);
      hd = (i == 13) ? 0 : (($urandom_range(0, 3) == 0) ? 1 : 0);
      if (prev_hold == 0) repeat ($urandom_range(0, 3)) tick();
      measure(w, (pk != 0), (hd != 0));
      prev_hold = hd;
    end
    start = 1'b0;
    repeat (3) tick();
    chk("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
